// File: rtl/dac_spi_tx.sv
// dac_spi_tx: FIFO-buffered 16-bit SPI serialiser with LDAC strobe for an MCP4921-class DAC
module dac_spi_tx #(
    parameter int         CLK_DIV    = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CFG_BITS   = 4'b0011
) (
    input  logic        Fg_clk,
    input  logic        Reset,
    input  logic [11:0] Sample,
    input  logic        Sample_valid,
    output logic        Sample_ready,
    output logic        Dac_sck,
    output logic        Dac_sdi,
    output logic        Dac_csn,
    output logic        Dac_ldacn,
    output logic        Busy,
    output logic        Overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, LDAC_PULSE} state_t;
    state_t        state;
    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic [7:0]    div;
    logic [3:0]    bit_cnt;
    logic [14:0]   sh;
    logic [15:0]   frame;
    logic          gap, push, pop, div_done;
    assign push     = Sample_valid && Sample_ready;
    assign pop      = state == IDLE && count != '0;
    assign div_done = div == 8'(CLK_DIV - 1);
    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
    assign frame    = {CFG_BITS, mem[rd_ptr]};
    always_ff @(posedge Fg_clk)
        if (push) mem[wr_ptr] <= Sample;
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            div          <= '0;
            bit_cnt      <= '0;
            sh           <= '0;
            gap          <= 1'b0;
            Sample_ready <= 1'b1;
            Dac_sck      <= 1'b0;
            Dac_sdi      <= 1'b0;
            Dac_csn      <= 1'b1;
            Dac_ldacn    <= 1'b1;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            count        <= count_nx;
            Sample_ready <= count_nx != (AW+1)'(FIFO_DEPTH);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (Sample_valid && !Sample_ready) Overrun <= 1'b1;
            div <= (state == IDLE || div_done) ? '0 : div + 8'd1;
            case (state)
                IDLE: if (pop) begin
                    sh      <= frame[14:0];
                    Dac_sdi <= frame[15];
                    Dac_csn <= 1'b0;
                    bit_cnt <= 4'd15;
                    Busy    <= 1'b1;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: if (div_done) begin
                    Dac_sck <= 1'b1;
                    state   <= SHIFT_HI;
                end
                SHIFT_HI: if (div_done) begin
                    Dac_sck <= 1'b0;
                    if (bit_cnt == 4'd0) state <= CS_HOLD;
                    else begin
                        bit_cnt <= bit_cnt - 4'd1;
                        Dac_sdi <= sh[14];
                        sh      <= {sh[13:0], 1'b0};
                        state   <= SHIFT_LO;
                    end
                end
                CS_HOLD: if (div_done) begin
                    Dac_csn   <= 1'b1;
                    Dac_ldacn <= 1'b0;
                    state     <= LDAC_PULSE;
                end
                // LDAC low for one division, then one more division of recovery before the next frame
                LDAC_PULSE: if (div_done) begin
                    if (!gap) begin
                        Dac_ldacn <= 1'b1;
                        gap       <= 1'b1;
                    end else begin
                        gap   <= 1'b0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: random and directed stimulus checked every cycle against a frame-timeline model
module tb_dac_spi_tx;
    localparam int MD = 2;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, valid, ready, sck, sdi, csn, ldacn, busy, ovr;
    logic [11:0] sample;
    logic r1, v1, ready1, sck1, sdi1, csn1, ldacn1, busy1, ovr1;
    logic [11:0] s1;
    dac_spi_tx #(.CLK_DIV(MD), .FIFO_DEPTH(DEPTH), .CFG_BITS(4'b0011)) dut (
        .Fg_clk(clk), .Reset(rst), .Sample(sample), .Sample_valid(valid), .Sample_ready(ready),
        .Dac_sck(sck), .Dac_sdi(sdi), .Dac_csn(csn), .Dac_ldacn(ldacn), .Busy(busy), .Overrun(ovr)
    );
    dac_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH), .CFG_BITS(4'b0011)) dut1 (
        .Fg_clk(clk), .Reset(r1), .Sample(s1), .Sample_valid(v1), .Sample_ready(ready1),
        .Dac_sck(sck1), .Dac_sdi(sdi1), .Dac_csn(csn1), .Dac_ldacn(ldacn1), .Busy(busy1), .Overrun(ovr1)
    );
    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask
    // model: FIFO as a queue, each frame as a timeline indexed by cycles since its pop
    logic [11:0] q[$];
    logic [11:0] acc[$];
    logic [15:0] tx[$];
    int starts[$];
    bit act, do_push, m_ready, m_ovr;
    int k, cyc, full_pop;
    logic [15:0] fr, cap;
    logic m_sdi, e_csn, e_sck, e_ldacn, e_busy;
    int nb, rises, csn_len, ldacn_len, busy_len, last_csn, last_ldacn, last_busy, ldacn_lows;
    logic p_sck = 1'b0, p_csn = 1'b1, p_ldacn = 1'b1, p_busy = 1'b0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete(); act = 0; k = 0; m_ready = 1; m_ovr = 0; m_sdi = 0; nb = 0;
        end else begin
            do_push = valid && m_ready;
            if (valid && !m_ready) m_ovr = 1;
            if (valid && !m_ready && !act && q.size() > 0) full_pop++;
            if (act) begin
                k++;
                if (k == 35 * MD) act = 0;
            end else if (q.size() > 0) begin
                fr = {4'h3, q.pop_front()};
                act = 1;
                k = 0;
            end
            if (do_push) begin
                q.push_back(sample);
                acc.push_back(sample);
            end
            m_ready = q.size() != DEPTH;
        end
        e_csn   = !(act && k < 33 * MD);
        e_sck   = act && k < 32 * MD && (k % (2 * MD)) >= MD;
        if (act && k < 32 * MD) m_sdi = fr[15 - k / (2 * MD)];
        e_ldacn = !(act && k >= 33 * MD && k < 34 * MD);
        e_busy  = act;
        #1;
        chk("outputs{ready,sck,sdi,csn,ldacn,busy,overrun}", {ready, sck, sdi, csn, ldacn, busy, ovr},
            {m_ready, e_sck, m_sdi, e_csn, e_ldacn, e_busy, m_ovr});
        if (!p_sck && sck) begin cap = {cap[14:0], sdi}; nb++; rises++; end
        if (p_csn && !csn) begin starts.push_back(cyc); nb = 0; rises = 0; end
        if (!csn) csn_len++;
        if (!p_csn && csn) begin last_csn = csn_len; csn_len = 0; if (nb == 16) tx.push_back(cap); end
        if (!ldacn) begin ldacn_len++; ldacn_lows++; end
        if (!p_ldacn && ldacn) begin last_ldacn = ldacn_len; ldacn_len = 0; end
        if (busy) busy_len++;
        if (p_busy && !busy) begin last_busy = busy_len; busy_len = 0; end
        p_sck = sck; p_csn = csn; p_ldacn = ldacn; p_busy = busy;
    end
    // CLK_DIV=1 instance, directed
    int lo1, ll1, ov1, n1;
    logic [15:0] c1;
    logic ps1;
    bit done1 = 0;
    initial begin
        r1 = 1; v1 = 0; s1 = 0; ps1 = 0; lo1 = 0; ll1 = 0; ov1 = 0; n1 = 0; c1 = 0;
        repeat (3) @(negedge clk);
        r1 = 0;
        v1 = 1; s1 = 12'h123;
        @(negedge clk);
        v1 = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (!csn1) lo1++;
            if (!ldacn1) ll1++;
            if (!csn1 && !ldacn1) ov1++;
            if (!ps1 && sck1) begin c1 = {c1[14:0], sdi1}; n1++; end
            ps1 = sck1;
        end
        chk("t6_csn_low", lo1, 33);
        chk("t6_ldacn_low", ll1, 1);
        chk("t6_overlap", ov1, 0);
        chk("t6_sck_rises", n1, 16);
        chk("t6_frame", c1, 16'h3123);
        done1 = 1;
    end
    logic [11:0] t2 [4] = '{12'h000, 12'hFFF, 12'h800, 12'h001};
    logic [15:0] t2f [4] = '{16'h3000, 16'h3FFF, 16'h3800, 16'h3001};
    int n;
    initial begin
        rst = 1; valid = 0; sample = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {ready, sck, sdi, csn, ldacn, busy, ovr}, 7'b1001100);
        rst = 0;
        valid = 1; sample = 12'hA5C;
        @(negedge clk);
        valid = 0;
        repeat (80) @(negedge clk);
        chk("t1_nframes", tx.size(), 1);
        chk("t1_frame", tx.size() > 0 ? tx[0] : 16'h0, 16'h3A5C);
        chk("t1_csn_low", last_csn, 66);
        chk("t1_ldacn_low", last_ldacn, 2);
        chk("t1_busy_high", last_busy, 70);
        tx.delete(); starts.delete();
        for (int i = 0; i < 4; i++) begin
            valid = 1; sample = t2[i];
            @(negedge clk);
        end
        valid = 0;
        repeat (4 * 71 + 10) @(negedge clk);
        chk("t2_nframes", tx.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_frame", tx.size() > i ? tx[i] : 16'h0, t2f[i]);
        for (int i = 1; i < 4; i++) chk("t2_spacing", starts.size() > i ? starts[i] - starts[i-1] : 0, 71);
        chk("t2_overrun", ovr, 0);
        tx.delete(); acc.delete(); full_pop = 0;
        valid = 1;
        for (int i = 0; i < 300; i++) begin
            sample = 12'(i + $urandom_range(0, 0));
            if ($urandom_range(0, 7) == 0) sample = 12'(i);
            @(negedge clk);
        end
        chk("t3_overrun_set", ovr, 1);
        valid = 0;
        repeat (5 * 71 + 10) @(negedge clk);
        chk("t3_overrun_held", ovr, 1);
        chk("t3_count", tx.size(), acc.size());
        for (int i = 0; i < acc.size() && i < tx.size(); i++) chk("t3_sample", tx[i][11:0], acc[i]);
        for (int i = 1; i < acc.size(); i++) chk("t3_no_dup", acc[i] > acc[i-1], 1);
        chk("t4_full_pop_seen", full_pop > 0, 1);
        tx.delete();
        valid = 1; sample = 12'($urandom);
        @(negedge clk);
        valid = 0;
        @(negedge clk);
        n = 0;
        while (rises < 9 && n < 1000) begin @(negedge clk); n++; end
        chk("t5_reach_bit7", rises, 9);
        ldacn_lows = 0;
        rst = 1;
        @(posedge clk);
        #2;
        chk("t5_after_reset", {ready, sck, sdi, csn, ldacn, busy, ovr}, 7'b1001100);
        @(negedge clk);
        rst = 0;
        repeat (100) @(negedge clk);
        chk("t5_no_ldac", ldacn_lows, 0);
        chk("t5_no_frame", tx.size(), 0);
        n = 0;
        while (!done1 && n < 500) begin @(negedge clk); n++; end
        chk("t6_done", done1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
